pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall-vector layout, FSM encoding, stop values.
package pipe_ctrl_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned STALL_W     = 6;
    localparam int unsigned RUN_CNT_W   = 16;
    localparam int unsigned FLUSH_CNT_W = 3;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam int unsigned PC_BIT    = 0;
    localparam int unsigned IFID_BIT  = 1;
    localparam int unsigned IDEX_BIT  = 2;
    localparam int unsigned EXMEM_BIT = 3;
    localparam int unsigned MEMWB_BIT = 4;
    localparam int unsigned RSVD_BIT  = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = (6'(STOP) << PC_BIT) | (6'(STOP) << IFID_BIT);
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_IF | (6'(STOP) << IDEX_BIT);
    localparam logic [STALL_W-1:0] STALL_EX   = STALL_ID | (6'(STOP) << EXMEM_BIT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Deepest requesting stage wins; writeback and the reserved bit never stall.
    function automatic logic [STALL_W-1:0] stall_vec(logic req_ex, logic req_id, logic req_if);
        logic [STALL_W-1:0] v;
        v = STALL_NONE;
        if (req_ex) begin
            v = STALL_EX;
        end else if (req_id) begin
            v = STALL_ID;
        end else if (req_if) begin
            v = STALL_IF;
        end
        v[MEMWB_BIT] = NO_STOP;
        v[RSVD_BIT]  = NO_STOP;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with stall watchdog.
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WD_LIMIT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        wdog_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    state_e                 state_q;
    state_e                 state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt_d;
    logic [RUN_CNT_W-1:0]   run_cnt_q;
    logic [RUN_CNT_W-1:0]   run_cnt_d;
    logic                   any_req;
    logic                   wdog_set;

    assign any_req = stallreq_if | stallreq_id | stallreq_ex;

    // Zero-latency stall vector; suppressed during reset and while flushing.
    always_comb begin
        stall_o = STALL_NONE;
        if (!rst && (state_q != ST_FLUSH)) begin
            stall_o = stall_vec(stallreq_ex, stallreq_id, stallreq_if);
        end
    end

    // Next state: a flush request overrides everything and restarts the flush count.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_req) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (any_req) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!any_req) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d = any_req ? ST_STALL : ST_RUN;
                    end else begin
                        flush_cnt_d = FLUSH_CNT_W'(flush_cnt_q - 1'b1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Consecutive STALL-state cycles, saturating.
    always_comb begin
        run_cnt_d = '0;
        if (state_q == ST_STALL) begin
            run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : RUN_CNT_W'(run_cnt_q + 1'b1);
        end
        wdog_set = (32'(run_cnt_d) >= WD_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            run_cnt_q   <= '0;
            flush_o     <= 1'b0;
            new_pc_o    <= ZERO_WORD;
            wdog_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            run_cnt_q   <= run_cnt_d;
            flush_o     <= (state_d == ST_FLUSH);
            if (flush_req) begin
                new_pc_o <= flush_pc;
            end
            if (wdog_set) begin
                wdog_o <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall_o != STALL_NONE) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (FLUSH_CYCLES=1/WD_LIMIT=4 and FLUSH_CYCLES=3/WD_LIMIT=255).
`timescale 1ns/1ps
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = 32'h0;

    logic [5:0]  a_stall;
    logic        a_flush;
    logic [31:0] a_pc;
    logic        a_wdog;
    logic [5:0]  b_stall;
    logic        b_flush;
    logic [31:0] b_pc;
    logic        b_wdog;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] a_cnt;
    logic [31:0] b_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(1), .WD_LIMIT(4)) u_a (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .stall_o(a_stall), .flush_o(a_flush), .new_pc_o(a_pc), .wdog_o(a_wdog)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt_o(a_cnt)
`endif
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .WD_LIMIT(255)) u_b (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .stall_o(b_stall), .flush_o(b_flush), .new_pc_o(b_pc), .wdog_o(b_wdog)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt_o(b_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, stall suppressed while rst is high
        stallreq_ex = 1'b1;
        #2;
        chk("rst_stall_a", 32'(a_stall), 32'h00);
        chk("rst_stall_b", 32'(b_stall), 32'h00);
        chk("rst_flush", 32'(a_flush), 32'h0);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_wdog", 32'(a_wdog), 32'h0);
        step();
        rst = 1'b0;
        stallreq_ex = 1'b0;

        // ex+id together: ex priority, STALL next cycle
        stallreq_ex = 1'b1;
        stallreq_id = 1'b1;
        #1;
        chk("exid_stall", 32'(a_stall), 32'h0F);
        step();
        chk("exid_state", 32'(u_a.state_q), 32'(ST_STALL));
        chk("exid_stall_held", 32'(a_stall), 32'h0F);
        stallreq_ex = 1'b0;
        stallreq_id = 1'b0;
        #1;
        chk("stall_idle", 32'(a_stall), 32'h00);
        step();
        chk("back_to_run", 32'(u_a.state_q), 32'(ST_RUN));
        stallreq_if = 1'b1;
        #1;
        chk("if_only", 32'(a_stall), 32'h03);
        stallreq_if = 1'b1;
        stallreq_id = 1'b1;
        #1;
        chk("id_over_if", 32'(a_stall), 32'h07);
        stallreq_if = 1'b0;
        stallreq_id = 1'b0;

        // Flush with concurrent id stall
        flush_req = 1'b1;
        flush_pc = 32'h0000_0180;
        stallreq_id = 1'b1;
        #1;
        chk("flush_cycle_stall", 32'(a_stall), 32'h07);
        step();
        flush_req = 1'b0;
        flush_pc = 32'h0;
        chk("flush_a_hi", 32'(a_flush), 32'h1);
        chk("flush_a_pc", a_pc, 32'h180);
        chk("flush_a_stall0", 32'(a_stall), 32'h00);
        chk("flush_b_hi", 32'(b_flush), 32'h1);
        step();
        chk("flush_a_lo", 32'(a_flush), 32'h0);
        chk("exit_to_stall", 32'(a_stall), 32'h07);
        chk("flush_b_still", 32'(b_flush), 32'h1);
        chk("flush_b_stall0", 32'(b_stall), 32'h00);

        // Second flush during b's flush restarts its count
        flush_req = 1'b1;
        flush_pc = 32'h0000_0200;
        stallreq_id = 1'b0;
        step();
        flush_req = 1'b0;
        flush_pc = 32'h0;
        chk("reflush_b_pc", b_pc, 32'h200);
        chk("reflush_b_1", 32'(b_flush), 32'h1);
        chk("reflush_a_hi", 32'(a_flush), 32'h1);
        step();
        chk("reflush_b_2", 32'(b_flush), 32'h1);
        chk("reflush_a_lo", 32'(a_flush), 32'h0);
        step();
        chk("reflush_b_3", 32'(b_flush), 32'h1);
        step();
        chk("reflush_b_end", 32'(b_flush), 32'h0);
        chk("pc_hold", b_pc, 32'h200);

        // Watchdog: ex held 6 cycles, limit 4 on instance a
        stallreq_ex = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("wdog_pre", 32'(a_wdog), 32'h0);
        step();
        chk("wdog_set", 32'(a_wdog), 32'h1);
        chk("wdog_b_clear", 32'(b_wdog), 32'h0);
        step();
        stallreq_ex = 1'b0;
        step();
        step();
        chk("wdog_sticky", 32'(a_wdog), 32'h1);

        // Reset mid-flush
        flush_req = 1'b1;
        flush_pc = 32'h0000_0300;
        step();
        flush_req = 1'b0;
        flush_pc = 32'h0;
        chk("preflush_hi", 32'(a_flush), 32'h1);
        chk("preflush_pc", a_pc, 32'h300);
        stallreq_ex = 1'b1;
        rst = 1'b1;
        #1;
        chk("rstmid_flush_a", 32'(a_flush), 32'h0);
        chk("rstmid_pc_a", a_pc, 32'h0);
        chk("rstmid_wdog_a", 32'(a_wdog), 32'h0);
        chk("rstmid_flush_b", 32'(b_flush), 32'h0);
        chk("rstmid_stall", 32'(a_stall), 32'h00);
        step();
        rst = 1'b0;
        #1;
        chk("release_stall", 32'(a_stall), 32'h0F);

        // 5 stall cycles, 2 idle, 2 stall
        step();
        chk("release_state", 32'(u_a.state_q), 32'(ST_STALL));
        chk("no_flush_a", 32'(a_flush), 32'h0);
        chk("no_flush_b", 32'(b_flush), 32'h0);
        for (int i = 0; i < 4; i++) step();
        stallreq_ex = 1'b0;
        step();
        step();
        stallreq_ex = 1'b1;
        step();
        step();
        stallreq_ex = 1'b0;
        step();
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_a", a_cnt, 32'd7);
        chk("perf_b", b_cnt, 32'd7);
`endif
        chk("end_flush_b", 32'(b_flush), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
